// File: rtl/rate_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : rate_seq_pkg
// Brief  : Shared state/speed encodings and divider reload helper.
// Rev    : 1.0  initial release
// ============================================================================
package rate_seq_pkg;

  localparam int unsigned RELOAD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SPD_EVERY = 2'b00,
    SPD_X1    = 2'b01,
    SPD_X2    = 2'b10,
    SPD_X4    = 2'b11
  } speed_e;

  // Terminal count for a speed; the tick period is this value plus one.
  function automatic logic [RELOAD_W-1:0] reload(input speed_e sel,
                                                 input logic [RELOAD_W-1:0] period_1);
    logic [RELOAD_W-1:0] r;
    r = '0;
    case (sel)
      SPD_EVERY: r = '0;
      SPD_X1:    r = period_1 - RELOAD_W'(1);
      SPD_X2:    r = (period_1 << 1) - RELOAD_W'(1);
      SPD_X4:    r = (period_1 << 2) - RELOAD_W'(1);
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rate_divider_core.sv
`default_nettype none
// ============================================================================
// Module : rate_divider_core
// Brief  : Loadable down-counter shared by every speed; stops at zero.
// Rev    : 1.0  initial release
// ============================================================================
module rate_divider_core #(
  parameter int unsigned QW = 28
) (
  input  logic          clock_i,
  input  logic          load_i,
  input  logic [QW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [QW-1:0] q_o,
  output logic          zero_o
);

  logic [QW-1:0] q_q;
  logic [QW-1:0] q_d;

  // No reset of its own: the owner asserts load during its reset.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      q_d = q_q - QW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    q_q <= q_d;
  end

  assign q_o    = q_q;
  assign zero_o = (q_q == '0);

endmodule
`default_nettype wire

// File: rtl/rate_sequencer.sv
`default_nettype none
// ============================================================================
// Module : rate_sequencer
// Brief  : Four-rate tick sequencer with deferred rate change and pause.
// Rev    : 1.0  initial release
// ============================================================================
module rate_sequencer
  import rate_seq_pkg::*;
#(
  parameter int unsigned PERIOD_1 = 50_000_000,
  parameter int unsigned QW       = 28
) (
  input  logic       clock_i,
  input  logic       clear_i,
  input  logic       run_en_i,
  input  logic [1:0] speed_sel_i,
  output logic       tick_o,
  output logic [3:0] count_o,
  output logic [1:0] speed_active_o,
  output logic       pending_o
);

  function automatic logic [QW-1:0] reload_qw(input speed_e s);
    return QW'(reload(s, RELOAD_W'(PERIOD_1)));
  endfunction

  state_e        state_q, state_d;
  logic          tick_q, tick_d;
  logic [3:0]    count_q, count_d;
  speed_e        speed_active_q, speed_active_d;
  logic          pending_q, pending_d;

  speed_e        w_sel;
  logic          w_load;
  logic          w_dec;
  logic [QW-1:0] w_q;
  logic          w_zero;

  assign w_sel = speed_e'(speed_sel_i);

  rate_divider_core #(
    .QW (QW)
  ) u_divider (
    .clock_i    (clock_i),
    .load_i     (clear_i | w_load),
    .load_val_i (reload_qw(w_sel)),
    .dec_i      (w_dec & ~clear_i),
    .q_o        (w_q),
    .zero_o     (w_zero)
  );

  always_comb begin
    state_d        = state_q;
    tick_d         = 1'b0;
    count_d        = count_q;
    speed_active_d = speed_active_q;
    pending_d      = pending_q;
    w_load         = 1'b0;
    w_dec          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_load         = 1'b1;
        speed_active_d = w_sel;
        pending_d      = 1'b0;
        if (run_en_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (run_en_i) begin
          state_d = ST_RUN;
          if (w_zero) begin
            tick_d         = 1'b1;
            count_d        = count_q + 4'd1;
            w_load         = 1'b1;
            speed_active_d = w_sel;
            pending_d      = 1'b0;
          end else begin
            w_dec     = 1'b1;
            pending_d = (w_sel != speed_active_q);
          end
        end else begin
          // Paused edges hold the period, except a new speed restarts it.
          state_d   = ST_PAUSE;
          pending_d = 1'b0;
          if (w_sel != speed_active_q) begin
            w_load         = 1'b1;
            speed_active_d = w_sel;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q        <= ST_IDLE;
      tick_q         <= 1'b0;
      count_q        <= 4'd0;
      speed_active_q <= w_sel;
      pending_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      count_q        <= count_d;
      speed_active_q <= speed_active_d;
      pending_q      <= pending_d;
    end
  end

  // The divider can never hold more than the active speed's reload value.
  always @(posedge clock_i) begin
    if (!clear_i) begin
      a_q_bounded: assert (w_q <= reload_qw(speed_active_q));
    end
  end

  assign tick_o         = tick_q;
  assign count_o        = count_q;
  assign speed_active_o = speed_active_q;
  assign pending_o      = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_rate_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_rate_sequencer
// Brief  : Scoreboard bench for rate_sequencer against a period-count model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rate_sequencer;

  localparam int unsigned P1 = 4;

  logic       clk       = 1'b0;
  logic       clear     = 1'b1;
  logic       run_en    = 1'b0;
  logic [1:0] speed_sel = 2'b10;
  logic       tick;
  logic [3:0] count;
  logic [1:0] spd_act;
  logic       pending;

  rate_sequencer #(
    .PERIOD_1 (P1),
    .QW       (8)
  ) dut (
    .clock_i        (clk),
    .clear_i        (clear),
    .run_en_i       (run_en),
    .speed_sel_i    (speed_sel),
    .tick_o         (tick),
    .count_o        (count),
    .speed_active_o (spd_act),
    .pending_o      (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic [3:0] cnt;
    logic [1:0] spd;
    logic       pend;
    int         cyc;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle_no = 0;

  // Reference model: counts elapsed active cycles within the current period.
  typedef enum {M_IDLE, M_RUN, M_PAUSE} mmode_e;
  mmode_e m_mode    = M_IDLE;
  int     m_elapsed = 0;
  int     m_act     = 2;
  int     m_count   = 0;
  bit     m_tick    = 1'b0;
  bit     m_pend    = 1'b0;

  function automatic int period_of(input int s);
    case (s)
      0:       return 1;
      1:       return P1;
      2:       return 2 * P1;
      default: return 4 * P1;
    endcase
  endfunction

  task automatic model_edge(input bit clr, input bit run, input int sel);
    exp_t e;
    if (clr) begin
      m_mode = M_IDLE; m_tick = 1'b0; m_count = 0; m_pend = 1'b0;
      m_act = sel; m_elapsed = 0;
    end else if (m_mode == M_IDLE) begin
      m_act = sel; m_elapsed = 0; m_tick = 1'b0; m_pend = 1'b0;
      if (run) m_mode = M_RUN;
    end else if (run) begin
      m_mode = M_RUN;
      if (m_elapsed == period_of(m_act) - 1) begin
        m_tick = 1'b1; m_count = (m_count + 1) % 16;
        m_act = sel; m_elapsed = 0; m_pend = 1'b0;
      end else begin
        m_tick = 1'b0; m_elapsed++; m_pend = (sel != m_act);
      end
    end else begin
      m_mode = M_PAUSE; m_tick = 1'b0; m_pend = 1'b0;
      if (sel != m_act) begin
        m_act = sel; m_elapsed = 0;
      end
    end
    e.tick = m_tick;
    e.cnt  = 4'(m_count);
    e.spd  = 2'(m_act);
    e.pend = m_pend;
    e.cyc  = cycle_no;
    expq.push_back(e);
  endtask

  task automatic cyc(input bit clr, input bit run, input int sel);
    @(negedge clk);
    clear     = clr;
    run_en    = run;
    speed_sel = 2'(sel);
    cycle_no++;
    model_edge(clr, run, sel);
  endtask

  task automatic run_until_tick(input int sel);
    for (int k = 0; k < 64; k++) begin
      cyc(1'b0, 1'b1, sel);
      if (m_tick) break;
    end
  endtask

  task automatic chk(input string name, input int cyc_n,
                     input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("tick",         e.cyc, 4'(tick),    4'(e.tick));
        chk("count",        e.cyc, count,       e.cnt);
        chk("speed_active", e.cyc, 4'(spd_act), 4'(e.spd));
        chk("pending",      e.cyc, 4'(pending), 4'(e.pend));
      end
    end
  end

  initial begin : stimulus
    int rsel;
    // Reset with speed 10, then one idle cycle.
    cyc(1'b1, 1'b0, 2);
    cyc(1'b0, 1'b0, 2);
    // Speed 01: enough ticks to wrap the counter.
    for (int i = 0; i < 70; i++) cyc(1'b0, 1'b1, 1);
    // Speed 00: tick every run cycle.
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 0);
    // Deferred switch 01 -> 11 one cycle after a tick.
    run_until_tick(1);
    cyc(1'b0, 1'b1, 1);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 3);
    // Pause two cycles mid-period.
    run_until_tick(1);
    cyc(1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 1);
    cyc(1'b0, 1'b0, 1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1);
    // Pause landing on the terminal-count edge.
    run_until_tick(1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1);
    // Clear mid-run while a change is pending; run_en held high.
    run_until_tick(3);
    cyc(1'b0, 1'b1, 3);
    cyc(1'b0, 1'b1, 1);
    cyc(1'b0, 1'b1, 1);
    cyc(1'b1, 1'b1, 1);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1);
    // Randomized traffic.
    rsel = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) rsel = int'($urandom_range(0, 3));
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85), rsel);
    end
    @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d queued expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
